// File: rtl/boids_pkg.sv
// boids_pkg: shared screen geometry, coordinate widths, colour indices and FSM state for the boid rasteriser
package boids_pkg;
  localparam int WIDTH = 640;
  localparam int HEIGHT = 480;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int ADDR_W = 19;
  localparam int PIX_W = 9;
  localparam int BG_COLOR = 31;
  localparam int BOID_COLOR = 42;
  typedef enum logic [1:0] {IDLE, ERASE, DRAW} state_t;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;
endpackage

// File: rtl/boid_square_scan.sv
// boid_square_scan: walks boid index, dy, dx one pixel per cycle, producing clipped framebuffer addresses and a done flag
module boid_square_scan #(
  parameter int NUM_BOIDS = 16,
  parameter int BOID_SIZE = 4,
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  localparam int IW = NUM_BOIDS > 1 ? $clog2(NUM_BOIDS) : 1,
  localparam int CW = $clog2(NUM_BOIDS + 1),
  localparam int SW = BOID_SIZE > 1 ? $clog2(BOID_SIZE) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [CW-1:0]                 cnt,
  input  logic [boids_pkg::X_W-1:0]     x,
  input  logic [boids_pkg::Y_W-1:0]     y,
  output logic [IW-1:0]                 idx,
  output logic [boids_pkg::ADDR_W-1:0]  addr,
  output logic                          wen,
  output logic                          done
);
  import boids_pkg::*;
  logic [SW-1:0] dx, dy;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic end_row, end_sq;
  always_comb begin
    px = {1'b0, x} + (X_W+1)'(dx);
    py = {1'b0, y} + (Y_W+1)'(dy);
    end_row = dx == SW'(BOID_SIZE - 1);
    end_sq = end_row && dy == SW'(BOID_SIZE - 1);
    done = run && end_sq && CW'(idx) + CW'(1) == cnt;
    wen = run && px < (X_W+1)'(WIDTH) && py < (Y_W+1)'(HEIGHT);
    addr = ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);
  end
  always_ff @(posedge clk)
    if (reset || done) begin
      idx <= '0;
      dx <= '0;
      dy <= '0;
    end else if (run) begin
      dx <= end_row ? '0 : dx + 1'b1;
      dy <= end_sq ? '0 : end_row ? dy + 1'b1 : dy;
      idx <= end_sq ? idx + 1'b1 : idx;
    end
endmodule

// File: rtl/boid_frame_writer.sv
// boid_frame_writer: loads boid position sets and rasterises them as squares into the framebuffer (erase phase enabled by BOID_FRAME_WRITER_ERASE_EN)
module boid_frame_writer #(
  parameter int NUM_BOIDS = 16,
  parameter int BOID_SIZE = 4,
  parameter int BG_COLOR = boids_pkg::BG_COLOR,
  parameter int BOID_COLOR = boids_pkg::BOID_COLOR,
  parameter int WIDTH = boids_pkg::WIDTH,
  parameter int HEIGHT = boids_pkg::HEIGHT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          pos_valid,
  output logic                          pos_ready,
  input  logic [boids_pkg::X_W-1:0]     pos_x,
  input  logic [boids_pkg::Y_W-1:0]     pos_y,
  input  logic                          pos_last,
  output logic [boids_pkg::ADDR_W-1:0]  fb_addr,
  output logic [boids_pkg::PIX_W-1:0]   fb_data,
  output logic                          fb_wen,
  output logic                          busy,
  output logic                          overrun
);
  import boids_pkg::*;
  localparam int IW = NUM_BOIDS > 1 ? $clog2(NUM_BOIDS) : 1;
  localparam int CW = $clog2(NUM_BOIDS + 1);
  state_t state;
  pos_t pend [NUM_BOIDS];
  pos_t cur [NUM_BOIDS];
  pos_t sq;
  logic [CW-1:0] pend_cnt, cur_cnt, cnt;
  logic pend_full, run, commit, wen, done;
  logic [IW-1:0] idx;
  logic [ADDR_W-1:0] addr;
`ifdef BOID_FRAME_WRITER_ERASE_EN
  pos_t prev [NUM_BOIDS];
  logic [CW-1:0] prev_cnt;
  always_comb begin
    cnt = state == ERASE ? prev_cnt : cur_cnt;
    sq = state == ERASE ? prev[idx] : cur[idx];
  end
`else
  always_comb begin
    cnt = cur_cnt;
    sq = cur[idx];
  end
`endif
  always_comb begin
    pos_ready = !pend_full;
    run = state != IDLE;
    commit = frame_start && !busy && pend_full;
  end
  boid_square_scan #(
    .NUM_BOIDS(NUM_BOIDS),
    .BOID_SIZE(BOID_SIZE),
    .WIDTH(WIDTH),
    .HEIGHT(HEIGHT)
  ) u_scan (
    .clk(clk),
    .reset(reset),
    .run(run),
    .cnt(cnt),
    .x(sq.x),
    .y(sq.y),
    .idx(idx),
    .addr(addr),
    .wen(wen),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (pos_valid && !pend_full && pend_cnt != CW'(NUM_BOIDS))
      pend[pend_cnt[IW-1:0]] <= {pos_x, pos_y};
    if (commit) begin
      cur <= pend;
`ifdef BOID_FRAME_WRITER_ERASE_EN
      prev <= cur;
`endif
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      pend_cnt <= '0;
      cur_cnt <= '0;
`ifdef BOID_FRAME_WRITER_ERASE_EN
      prev_cnt <= '0;
`endif
      pend_full <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
      fb_wen <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      busy <= run || commit;
      overrun <= overrun || (frame_start && busy);
      fb_wen <= wen;
      if (run) begin
        fb_addr <= addr;
        fb_data <= state == ERASE ? PIX_W'(BG_COLOR) : PIX_W'(BOID_COLOR);
      end
      if (commit) begin
        pend_cnt <= '0;
        pend_full <= 1'b0;
        cur_cnt <= pend_cnt;
`ifdef BOID_FRAME_WRITER_ERASE_EN
        prev_cnt <= cur_cnt;
        state <= cur_cnt != '0 ? ERASE : DRAW;
`else
        state <= DRAW;
`endif
      end else begin
        if (pos_valid && !pend_full) begin
          pend_cnt <= pend_cnt + CW'(pend_cnt != CW'(NUM_BOIDS));
          pend_full <= pos_last;
        end
        if (done)
          state <= state == ERASE ? DRAW : IDLE;
      end
    end
endmodule

// File: doc/boid_frame_writer.md
# boid_frame_writer

- Upstream stage of the VGA display path.
- Takes per-frame boid position sets from the boid compute logic and rasterises each boid as a filled square into the pixel framebuffer (640×480 palette-index RAM) through its write port.
- On each frame boundary it erases the previous frame's squares to the background colour index, then draws the new squares. The VGA scan-out reads the framebuffer and renders the result.

## Interface
Parameters:
- NUM_BOIDS, 16: maximum boids per set.
- BOID_SIZE, 4: square edge in pixels.
- BG_COLOR, 31: palette index written on erase.
- BOID_COLOR, 42: palette index written on draw.
- WIDTH, 640: visible width in pixels.
- HEIGHT, 480: visible height in pixels.

Ports:
- clk  in  1  100 MHz system clock; the only clock.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse in the clk domain at the frame boundary.
- pos_valid  in  1  position beat valid.
- pos_ready  out  1  block can accept a beat.
- pos_x  in  10  boid top-left x.
- pos_y  in  9  boid top-left y.
- pos_last  in  1  beat is the final one of the set.
- fb_addr  out  19  framebuffer write address.
- fb_data  out  9  palette index to write.
- fb_wen  out  1  framebuffer write enable.
- busy  out  1  erase/draw in progress.
- overrun  out  1  sticky; a frame_start was dropped.

## Operation
- **Load**
  - A beat transfers when pos_valid && pos_ready.
  - The beat is stored in the pending array at index pend_cnt, and pend_cnt increments.
  - Once pend_cnt = NUM_BOIDS, further beats are accepted but discarded; pend_cnt saturates.
  - A transfer with pos_last set marks the set complete (pend_full=1). pos_ready = !pend_full.
- **Commit**
  - Occurs on frame_start in IDLE with pend_full=1.
  - prev ← cur, prev_cnt ← cur_cnt, cur ← pending, cur_cnt ← pend_cnt.
  - pend_cnt ← 0, pend_full ← 0, state ← ERASE.
  - frame_start in IDLE with pend_full=0: no action, no writes.
- **FSM states:** IDLE, ERASE, DRAW.
  - ERASE walks prev[0..prev_cnt-1], then goes to DRAW. If prev_cnt=0, it skips straight to DRAW.
  - DRAW walks cur[0..cur_cnt-1], then returns to IDLE.
  - Scan order: boid index outermost, then dy, then dx, each 0..BOID_SIZE-1. One pixel per cycle.
- **Address**
  - addr = (y+dy)*WIDTH + (x+dx), computed at 19 bits; no wrap.
  - Clipping: a pixel with x+dx ≥ WIDTH or y+dy ≥ HEIGHT still consumes its cycle, with fb_wen=0.
- **Write data:** fb_data = BG_COLOR in ERASE, BOID_COLOR in DRAW.
- **Overrun:** frame_start while busy is ignored, sets overrun, and leaves pending untouched. overrun clears only on reset.
- **Simultaneous events**
  - A pos_last transfer in the same cycle as frame_start does not commit; the set commits at the next frame_start.
  - Loading continues during ERASE/DRAW.
- **Reset mid-operation:** aborts the walk; all counts and flags are cleared. The framebuffer content is left as-is.

## Timing
- Reset values: fb_wen=0, fb_addr=0, fb_data=0, pos_ready=1, busy=0, overrun=0, state=IDLE.
- Commit on edge t:
  - busy=1 from cycle t+1.
  - First fb_wen pulse in cycle t+2; fb_* are registered, so generation-to-output latency is 1 cycle.
- Pixel counts: ERASE occupies prev_cnt·BOID_SIZE² cycles, DRAW occupies cur_cnt·BOID_SIZE² cycles, with no gap between them.
- busy falls the cycle after the last DRAW write is presented.
- pos_ready falls the cycle after the pos_last transfer and rises the cycle after commit.

## Configuration
- BOID_FRAME_WRITER_ERASE_EN defined: the ERASE phase and prev array are implemented, as described above.
- Undefined:
  - No prev array.
  - Commit goes IDLE→DRAW directly, and first fb_wen is still at t+2.
  - Previous squares persist, producing a trail effect.

## Structure
- boids_pkg holds:
  - screen constants WIDTH, HEIGHT;
  - coordinate widths (X_W=10, Y_W=9, ADDR_W=19, PIX_W=9);
  - BG/BOID colour indices;
  - the state enum (IDLE, ERASE, DRAW).
- One sub-module, boid_square_scan:
  - dx/dy/index counters;
  - clipping;
  - address multiply-add;
  - done flag.
- The top level holds the pending/cur/prev arrays, the FSM and the output registers.

## Test plan
- **Basic draw:** load one boid (100,50) with pos_last, then pulse frame_start → 16 writes of 42, first at addr 32100, last at 34023, busy low afterward.
- **Move and erase:** second set (101,50), then frame_start → 16 writes of 31 at the old square, then 16 writes of 42 at the new square (ERASE_EN build); without the macro only the 16 draws occur.
- **Clipping:** boid at (638,478) → 16 scan cycles, fb_wen high only for the 4 pixels at x 638–639, y 478–479.
- **Overflow:** 20 beats, last flagged → 16 boids drawn (256 writes); pos_ready low until commit.
- **Overrun:** frame_start during DRAW → ignored, overrun=1, pending set commits on the next idle frame_start.
- **Reset mid-ERASE:** assert reset → next cycle fb_wen=0, busy=0, pos_ready=1; a later frame_start produces no writes.
